// File: rtl/ingress_pkg.sv
// Shared types for the byte-stream ingress path: byte width, decoder states
// and the internal frame-error cause codes.
package ingress_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        HDR,
        PAY
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        BAD_HDR,
        SYNC_ABORT,
        TIMEOUT
    } err_cause_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy level.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; an empty FIFO masks dout, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sample_stream_deserializer.sv
// Decodes header-tagged, MSB-first multi-byte samples from a byte stream into a FWFT output FIFO.
// Optional payload idle timeout is built only when SAMPLE_TIMEOUT_EN is defined.
module sample_stream_deserializer
    import ingress_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_CHANNELS   = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [BYTE_W-1:0]               byte_in,
    input  logic                            byte_valid,
    input  logic                            sync,
    output logic [DATA_WIDTH-1:0]           sample_out,
    output logic [$clog2(NUM_CHANNELS)-1:0] sample_ch,
    output logic                            sample_valid,
    input  logic                            sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    input  logic                            overflow_clr,
    output logic                            frame_err
);

    localparam int NBYTES = DATA_WIDTH / BYTE_W;
    localparam int CH_W   = $clog2(NUM_CHANNELS);
    localparam int CNT_W  = $clog2(NBYTES) + 1;

    if (DATA_WIDTH % BYTE_W != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES at least 1");
    end

    state_t                 state_q, state_d;
    err_cause_t             err_cause;
    logic [CH_W-1:0]        ch_q;
    logic [DATA_WIDTH-1:0]  shreg_q;
    logic [DATA_WIDTH-1:0]  sample_next;
    logic [CNT_W-1:0]       byte_cnt_q;
    logic [BYTE_W-1:0]      hdr_upper;
    logic                   hdr_accept;
    logic                   pay_shift;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   timeout_hit;
    logic                   frame_err_q;
    logic                   overflow_q;

    assign hdr_upper   = byte_in >> CH_W;
    assign sample_next = (shreg_q << BYTE_W) | DATA_WIDTH'(byte_in);

`ifdef SAMPLE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                               idle_cnt_q <= '0;
        else if (state_q != PAY || byte_valid || state_d == HDR)  idle_cnt_q <= '0;
        else                                                      idle_cnt_q <= idle_cnt_q + 1'b1;
    end

    assign timeout_hit = (state_q == PAY) && !sync && !byte_valid &&
                         (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HDR;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        err_cause  = ERR_NONE;
        hdr_accept = 1'b0;
        pay_shift  = 1'b0;
        push       = 1'b0;

        if (sync && state_q == PAY) err_cause = SYNC_ABORT;
        else if (timeout_hit)       err_cause = TIMEOUT;
        if (sync || timeout_hit)    state_d   = HDR;

        // A sync in the same cycle aborts first, so the byte is always decoded as a header.
        if (byte_valid) begin
            if (sync || state_q == HDR) begin
                if (hdr_upper == '0) begin
                    hdr_accept = 1'b1;
                    state_d    = PAY;
                end else if (err_cause == ERR_NONE) begin
                    err_cause = BAD_HDR;
                end
            end else begin
                pay_shift = 1'b1;
                if (byte_cnt_q == CNT_W'(NBYTES - 1)) begin
                    push    = 1'b1;
                    state_d = HDR;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q       <= '0;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
        end else begin
            if (hdr_accept) ch_q <= byte_in[CH_W-1:0];
            if (hdr_accept)     shreg_q <= '0;
            else if (pay_shift) shreg_q <= sample_next;
            if (state_d == HDR || hdr_accept) byte_cnt_q <= '0;
            else if (pay_shift)               byte_cnt_q <= byte_cnt_q + 1'b1;
        end
    end

    assign pop = !fifo_empty && sample_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= (err_cause != ERR_NONE);
            if (push && fifo_full && !pop) overflow_q <= 1'b1;
            else if (overflow_clr)         overflow_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH(CH_W + DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .din  ({ch_q, sample_next}),
        .pop  (pop),
        .dout ({sample_ch, sample_out}),
        .level(fifo_level),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign sample_valid = !fifo_empty;
    assign overflow     = overflow_q;
    assign frame_err    = frame_err_q;

endmodule
